// File: rtl/out_sram_writeback.sv
// Output-SRAM writeback stage: buffers drained PE-array rows, generates write addresses and partial-tile bit enables.
// Optional macro OUT_WB_ZERO_PAD_EN: out-of-range rows/lanes are written as zeros, so every tile writes all rows.

module out_sram_writeback #(
    parameter int ACC_BWIDTH             = 32,
    parameter int PE_ARRAY_NUM_ROWS      = 32,
    parameter int PE_ARRAY_NUM_ROWS_LOG2 = 5,
    parameter int PE_ARRAY_NUM_COLS      = 32,
    parameter int OUT_SRAM_AWIDTH        = 10,
    parameter int OUT_SRAM_BWIDTH        = 32*32,
    parameter int MAX_M_SIZE_LOG2        = 9,
    parameter int MAX_N_SIZE_LOG2        = 9,
    parameter int BUF_DEPTH              = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       STALL,
    input  logic                       TILE_START_in,
    input  logic [MAX_M_SIZE_LOG2-1:0] TILE_ROW_BASE_in,
    input  logic [MAX_N_SIZE_LOG2-1:0] TILE_COL_BASE_in,
    input  logic [OUT_SRAM_AWIDTH-1:0] BASE_ADDR_in,
    input  logic [MAX_M_SIZE_LOG2-1:0] M_SIZE_in,
    input  logic [MAX_N_SIZE_LOG2-1:0] N_SIZE_in,
    input  logic                       ROW_VALID_in,
    input  logic [OUT_SRAM_BWIDTH-1:0] ROW_DATA_in,
    output logic                       ROW_READY_out,
    output logic [OUT_SRAM_AWIDTH-1:0] OUT_SRAM_ADDR_out,
    output logic                       OUT_SRAM_WEn_out,
    output logic [OUT_SRAM_BWIDTH-1:0] OUT_SRAM_BE_out,
    output logic [OUT_SRAM_BWIDTH-1:0] OUT_SRAM_D_out,
    output logic                       BUSY_out,
    output logic                       TILE_DONE_out
);

    localparam int ROWCNT_W = PE_ARRAY_NUM_ROWS_LOG2 + 1;
    localparam int COLCNT_W = $clog2(PE_ARRAY_NUM_COLS) + 1;
    localparam int PTR_W    = $clog2(BUF_DEPTH);
    localparam int OCC_W    = PTR_W + 1;
    localparam logic [ROWCNT_W-1:0] ROWS_FULL = ROWCNT_W'(PE_ARRAY_NUM_ROWS);
    localparam logic [COLCNT_W-1:0] COLS_FULL = COLCNT_W'(PE_ARRAY_NUM_COLS);
    localparam logic [OCC_W-1:0]    OCC_FULL  = OCC_W'(BUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_DONE} state_t;

    typedef struct packed {
        logic [OUT_SRAM_BWIDTH-1:0]        data;
        logic [PE_ARRAY_NUM_ROWS_LOG2-1:0] idx;
    } entry_t;

    state_t                     state_q, state_d;
    logic [OUT_SRAM_AWIDTH-1:0] base_q;
    logic [ROWCNT_W-1:0]        vrows_q, vrows_new, accept_q, accept_d;
    logic [COLCNT_W-1:0]        vcols_q, vcols_new;
    logic                       ready_q, ready_d;
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]           occ_q, occ_d;
    logic [MAX_M_SIZE_LOG2-1:0] m_rem;
    logic [MAX_N_SIZE_LOG2-1:0] n_rem;
    logic [OUT_SRAM_BWIDTH-1:0] lane_mask;
    logic                       push, pop, in_range;
    entry_t                     rd_entry;
    entry_t                     fifo_mem [BUF_DEPTH];

    assign push     = ROW_VALID_in && ready_q;
    assign pop      = !STALL && (occ_q != '0);
    assign occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
    assign accept_d = accept_q + ROWCNT_W'(push);
    assign rd_entry = fifo_mem[rd_ptr_q];
    assign in_range = {1'b0, rd_entry.idx} < vrows_q;
    assign m_rem    = M_SIZE_in - TILE_ROW_BASE_in;
    assign n_rem    = N_SIZE_in - TILE_COL_BASE_in;

    // Tile bounds are evaluated from the live config inputs and captured on TILE_START.
    always_comb begin
        // NOTE: every always_comb output is given a default first so no latch is inferred.
        vrows_new = '0;
        vcols_new = '0;
        if (TILE_ROW_BASE_in < M_SIZE_in)
            vrows_new = (m_rem >= MAX_M_SIZE_LOG2'(PE_ARRAY_NUM_ROWS)) ? ROWS_FULL : m_rem[ROWCNT_W-1:0];
        if (TILE_COL_BASE_in < N_SIZE_in)
            vcols_new = (n_rem >= MAX_N_SIZE_LOG2'(PE_ARRAY_NUM_COLS)) ? COLS_FULL : n_rem[COLCNT_W-1:0];
    end

    always_comb begin
        lane_mask = '0;
        for (int j = 0; j < PE_ARRAY_NUM_COLS; j++)
            if (COLCNT_W'(j) < vcols_q)
                lane_mask[j*ACC_BWIDTH +: ACC_BWIDTH] = '1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (TILE_START_in) state_d = S_DRAIN;
            S_DRAIN: if (accept_d == ROWS_FULL) state_d = S_FLUSH;
            S_FLUSH: if (occ_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // READY is registered: it looks ahead at next-cycle occupancy, never at STALL.
        ready_d = (state_d == S_DRAIN) && (occ_d != OCC_FULL);
    end

    // NOTE: buffer storage is not reset; the pointers and occupancy alone define which entries are live.
    always_ff @(posedge CLK) begin
        if (push)
            fifo_mem[wr_ptr_q] <= '{data: ROW_DATA_in, idx: accept_q[PE_ARRAY_NUM_ROWS_LOG2-1:0]};
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (RST) begin
            state_q          <= S_IDLE;
            base_q           <= '0;
            vrows_q          <= '0;
            vcols_q          <= '0;
            accept_q         <= '0;
            ready_q          <= 1'b0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            occ_q            <= '0;
            OUT_SRAM_ADDR_out <= '0;
            OUT_SRAM_WEn_out <= 1'b1;
            OUT_SRAM_BE_out  <= '0;
            OUT_SRAM_D_out   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            occ_q   <= occ_d;
            if (state_q == S_IDLE) begin
                accept_q <= '0;
                if (TILE_START_in) begin
                    base_q  <= BASE_ADDR_in;
                    vrows_q <= vrows_new;
                    vcols_q <= vcols_new;
                end
            end else begin
                accept_q <= accept_d;
            end
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);

            OUT_SRAM_WEn_out <= 1'b1;
            OUT_SRAM_BE_out  <= '0;
            if (pop) begin
`ifdef OUT_WB_ZERO_PAD_EN
                OUT_SRAM_WEn_out  <= 1'b0;
                OUT_SRAM_ADDR_out <= base_q + OUT_SRAM_AWIDTH'(rd_entry.idx);
                OUT_SRAM_D_out    <= in_range ? (rd_entry.data & lane_mask) : '0;
                OUT_SRAM_BE_out   <= '1;
`else
                if (in_range) begin
                    OUT_SRAM_WEn_out  <= 1'b0;
                    OUT_SRAM_ADDR_out <= base_q + OUT_SRAM_AWIDTH'(rd_entry.idx);
                    OUT_SRAM_D_out    <= rd_entry.data;
                    OUT_SRAM_BE_out   <= lane_mask;
                end
`endif
            end
        end
    end

    assign ROW_READY_out = ready_q;
    assign BUSY_out      = (state_q == S_DRAIN) || (state_q == S_FLUSH);
    assign TILE_DONE_out = (state_q == S_DONE);

endmodule

// File: tb/tb_out_sram_writeback.sv
// Directed bench for out_sram_writeback: full/partial tiles, stall, mid-tile reset, ignored start, empty tile.
// Expectations follow the OUT_WB_ZERO_PAD_EN macro when the bench is built with it.

module tb_out_sram_writeback;

    localparam int ACC = 32;
    localparam int COLS = 32;
    localparam int ROWS = 32;
    localparam int AW = 10;
    localparam int BW = ACC*COLS;

    logic          clk = 1'b0;
    logic          RST, STALL, TILE_START_in, ROW_VALID_in;
    logic [8:0]    TILE_ROW_BASE_in, TILE_COL_BASE_in, M_SIZE_in, N_SIZE_in;
    logic [AW-1:0] BASE_ADDR_in;
    logic [BW-1:0] ROW_DATA_in;
    logic          ROW_READY_out, OUT_SRAM_WEn_out, BUSY_out, TILE_DONE_out;
    logic [AW-1:0] OUT_SRAM_ADDR_out;
    logic [BW-1:0] OUT_SRAM_BE_out, OUT_SRAM_D_out;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic done_busy = 1'b0;

    logic [AW-1:0] wr_addr_q[$];
    logic [BW-1:0] wr_d_q[$];
    logic [BW-1:0] wr_be_q[$];
    int            wr_cyc_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [BW-1:0] exp_d_q[$];
    logic [BW-1:0] exp_be_q[$];

    always #5 clk = ~clk;

    out_sram_writeback dut (
        .CLK(clk), .RST(RST), .STALL(STALL), .TILE_START_in(TILE_START_in),
        .TILE_ROW_BASE_in(TILE_ROW_BASE_in), .TILE_COL_BASE_in(TILE_COL_BASE_in),
        .BASE_ADDR_in(BASE_ADDR_in), .M_SIZE_in(M_SIZE_in), .N_SIZE_in(N_SIZE_in),
        .ROW_VALID_in(ROW_VALID_in), .ROW_DATA_in(ROW_DATA_in), .ROW_READY_out(ROW_READY_out),
        .OUT_SRAM_ADDR_out(OUT_SRAM_ADDR_out), .OUT_SRAM_WEn_out(OUT_SRAM_WEn_out),
        .OUT_SRAM_BE_out(OUT_SRAM_BE_out), .OUT_SRAM_D_out(OUT_SRAM_D_out),
        .BUSY_out(BUSY_out), .TILE_DONE_out(TILE_DONE_out)
    );

    // Write/DONE monitor, sampled 1 time unit after each rising edge; cyc counts rising edges.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (OUT_SRAM_WEn_out === 1'b0) begin
            wr_addr_q.push_back(OUT_SRAM_ADDR_out);
            wr_d_q.push_back(OUT_SRAM_D_out);
            wr_be_q.push_back(OUT_SRAM_BE_out);
            wr_cyc_q.push_back(cyc);
        end
        if (TILE_DONE_out === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            done_busy = BUSY_out;
        end
    end

    function automatic logic [BW-1:0] row_word(input int r, input int tag);
        logic [BW-1:0] w;
        for (int j = 0; j < COLS; j++)
            w[j*ACC +: ACC] = (tag == 0) ? r : ((tag << 16) | (r << 8) | j);
        return w;
    endfunction

    function automatic logic [BW-1:0] mask_of(input int vc);
        logic [BW-1:0] m = '0;
        for (int j = 0; j < vc; j++) m[j*ACC +: ACC] = '1;
        return m;
    endfunction

    task automatic build_expected(input int base, input int vr, input int vc, input int tag);
        exp_addr_q.delete(); exp_d_q.delete(); exp_be_q.delete();
        for (int r = 0; r < ROWS; r++) begin
`ifdef OUT_WB_ZERO_PAD_EN
            exp_addr_q.push_back(AW'((base + r) % 1024));
            exp_d_q.push_back((r < vr) ? (row_word(r, tag) & mask_of(vc)) : '0);
            exp_be_q.push_back('1);
`else
            if (r < vr) begin
                exp_addr_q.push_back(AW'((base + r) % 1024));
                exp_d_q.push_back(row_word(r, tag));
                exp_be_q.push_back(mask_of(vc));
            end
`endif
        end
    endtask

    task automatic clear_mon();
        wr_addr_q.delete(); wr_d_q.delete(); wr_be_q.delete(); wr_cyc_q.delete();
        done_cnt = 0;
    endtask

    task automatic start_tile(input int base, input int m, input int n, input int rb, input int cb, input logic stall);
        @(negedge clk);
        BASE_ADDR_in = AW'(base);
        M_SIZE_in = 9'(m); N_SIZE_in = 9'(n);
        TILE_ROW_BASE_in = 9'(rb); TILE_COL_BASE_in = 9'(cb);
        STALL = stall;
        TILE_START_in = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic stream_rows(input int from, input int to, input int tag, input string name);
        int r = from;
        int n = 0;
        while (r < to) begin
            @(negedge clk);
            TILE_START_in = 1'b0;
            ROW_VALID_in = 1'b1;
            ROW_DATA_in = row_word(r, tag);
            if (ROW_READY_out === 1'b1) r++;
            n++;
            if (n > 400) begin
                total_cnt++;
                $display("FAIL %s stream_timeout: accepted %0d rows, required %0d", name, r, to);
                break;
            end
        end
        @(negedge clk);
        ROW_VALID_in = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (done_cnt == 0) $display("FAIL %s done_timeout: no TILE_DONE within %0d cycles", name, n);
        else pass_cnt++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        RST = 1'b1; STALL = 1'b0; TILE_START_in = 1'b0; ROW_VALID_in = 1'b0; ROW_DATA_in = '0;
        BASE_ADDR_in = '0; M_SIZE_in = '0; N_SIZE_in = '0; TILE_ROW_BASE_in = '0; TILE_COL_BASE_in = '0;
        repeat (3) @(negedge clk);
        total_cnt++; if (OUT_SRAM_ADDR_out !== '0) $display("FAIL reset addr: got %0d exp 0", OUT_SRAM_ADDR_out); else pass_cnt++;
        total_cnt++; if (OUT_SRAM_WEn_out !== 1'b1) $display("FAIL reset wen: got %b exp 1", OUT_SRAM_WEn_out); else pass_cnt++;
        total_cnt++; if (OUT_SRAM_BE_out !== '0) $display("FAIL reset be: got lane0 %h exp 0", OUT_SRAM_BE_out[31:0]); else pass_cnt++;
        total_cnt++; if (OUT_SRAM_D_out !== '0) $display("FAIL reset d: got lane0 %h exp 0", OUT_SRAM_D_out[31:0]); else pass_cnt++;
        total_cnt++; if (ROW_READY_out !== 1'b0) $display("FAIL reset ready: got %b exp 0", ROW_READY_out); else pass_cnt++;
        total_cnt++; if (BUSY_out !== 1'b0) $display("FAIL reset busy: got %b exp 0", BUSY_out); else pass_cnt++;
        total_cnt++; if (TILE_DONE_out !== 1'b0) $display("FAIL reset done: got %b exp 0", TILE_DONE_out); else pass_cnt++;
        RST = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_tile();
        int c0;
        clear_mon();
        build_expected(100, 32, 32, 0);
        start_tile(100, 64, 64, 0, 32, 1'b0);
        c0 = start_cyc;
        stream_rows(0, ROWS, 0, "full");
        wait_done("full");
        total_cnt++;
        if (wr_addr_q.size() != exp_addr_q.size()) $display("FAIL full write_count: got %0d exp %0d", wr_addr_q.size(), exp_addr_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            total_cnt++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_d_q[i] !== exp_d_q[i] || wr_be_q[i] !== exp_be_q[i])
                $display("FAIL full write%0d: got addr=%0d d0=%h be0=%h, exp addr=%0d d0=%h be0=%h", i,
                         wr_addr_q[i], wr_d_q[i][31:0], wr_be_q[i][31:0], exp_addr_q[i], exp_d_q[i][31:0], exp_be_q[i][31:0]);
            else pass_cnt++;
        end
        if (wr_cyc_q.size() == 32) begin
            total_cnt++; if (wr_cyc_q[0] != c0 + 3) $display("FAIL full first_write_cycle: got %0d exp %0d", wr_cyc_q[0], c0 + 3); else pass_cnt++;
            total_cnt++; if (wr_cyc_q[31] != c0 + 34) $display("FAIL full last_write_cycle: got %0d exp %0d", wr_cyc_q[31], c0 + 34); else pass_cnt++;
        end
        total_cnt++; if (done_cyc != c0 + 35) $display("FAIL full done_cycle: got %0d exp %0d", done_cyc, c0 + 35); else pass_cnt++;
        total_cnt++; if (done_cnt != 1) $display("FAIL full done_count: got %0d exp 1", done_cnt); else pass_cnt++;
        total_cnt++; if (done_busy !== 1'b0) $display("FAIL full busy_at_done: got %b exp 0", done_busy); else pass_cnt++;
    endtask

    task automatic test_partial_tile();
        clear_mon();
        build_expected(600, 8, 5, 1);
        start_tile(600, 40, 37, 32, 32, 1'b0);
        stream_rows(0, ROWS, 1, "partial");
        wait_done("partial");
        total_cnt++;
        if (wr_addr_q.size() != exp_addr_q.size()) $display("FAIL partial write_count: got %0d exp %0d", wr_addr_q.size(), exp_addr_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            total_cnt++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_d_q[i] !== exp_d_q[i] || wr_be_q[i] !== exp_be_q[i])
                $display("FAIL partial write%0d: got addr=%0d d5=%h be5=%h be4=%h, exp addr=%0d d5=%h be5=%h be4=%h", i,
                         wr_addr_q[i], wr_d_q[i][191:160], wr_be_q[i][191:160], wr_be_q[i][159:128],
                         exp_addr_q[i], exp_d_q[i][191:160], exp_be_q[i][191:160], exp_be_q[i][159:128]);
            else pass_cnt++;
        end
        total_cnt++; if (done_cnt != 1) $display("FAIL partial done_count: got %0d exp 1", done_cnt); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int r = 0;
        clear_mon();
        build_expected(200, 32, 32, 2);
        start_tile(200, 64, 64, 0, 0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            TILE_START_in = 1'b0;
            ROW_VALID_in = 1'b1;
            ROW_DATA_in = row_word(r, 2);
            if (ROW_READY_out === 1'b1) r++;
        end
        total_cnt++; if (r != 4) $display("FAIL stall accepts: got %0d exp 4", r); else pass_cnt++;
        total_cnt++; if (ROW_READY_out !== 1'b0) $display("FAIL stall ready: got %b exp 0", ROW_READY_out); else pass_cnt++;
        total_cnt++; if (wr_addr_q.size() != 0) $display("FAIL stall writes_during_stall: got %0d exp 0", wr_addr_q.size()); else pass_cnt++;
        STALL = 1'b0;
        stream_rows(r, ROWS, 2, "stall");
        wait_done("stall");
        total_cnt++;
        if (wr_addr_q.size() != exp_addr_q.size()) $display("FAIL stall write_count: got %0d exp %0d", wr_addr_q.size(), exp_addr_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            total_cnt++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_d_q[i] !== exp_d_q[i] || wr_be_q[i] !== exp_be_q[i])
                $display("FAIL stall write%0d: got addr=%0d d0=%h, exp addr=%0d d0=%h", i,
                         wr_addr_q[i], wr_d_q[i][31:0], exp_addr_q[i], exp_d_q[i][31:0]);
            else pass_cnt++;
        end
        total_cnt++; if (done_cnt != 1) $display("FAIL stall done_count: got %0d exp 1", done_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid_tile();
        clear_mon();
        start_tile(400, 64, 64, 0, 0, 1'b0);
        stream_rows(0, 10, 3, "midreset");
        RST = 1'b1;
        @(negedge clk);
        total_cnt++; if (OUT_SRAM_WEn_out !== 1'b1) $display("FAIL midreset wen: got %b exp 1", OUT_SRAM_WEn_out); else pass_cnt++;
        total_cnt++; if (OUT_SRAM_BE_out !== '0) $display("FAIL midreset be: got lane0 %h exp 0", OUT_SRAM_BE_out[31:0]); else pass_cnt++;
        total_cnt++; if (BUSY_out !== 1'b0) $display("FAIL midreset busy: got %b exp 0", BUSY_out); else pass_cnt++;
        total_cnt++; if (ROW_READY_out !== 1'b0) $display("FAIL midreset ready: got %b exp 0", ROW_READY_out); else pass_cnt++;
        RST = 1'b0;
        clear_mon();
        build_expected(1000, 32, 32, 4);
        start_tile(1000, 64, 64, 0, 0, 1'b0);
        stream_rows(0, ROWS, 4, "postreset");
        wait_done("postreset");
        total_cnt++;
        if (wr_addr_q.size() != exp_addr_q.size()) $display("FAIL postreset write_count: got %0d exp %0d", wr_addr_q.size(), exp_addr_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            total_cnt++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_d_q[i] !== exp_d_q[i] || wr_be_q[i] !== exp_be_q[i])
                $display("FAIL postreset write%0d: got addr=%0d d0=%h, exp addr=%0d d0=%h", i,
                         wr_addr_q[i], wr_d_q[i][31:0], exp_addr_q[i], exp_d_q[i][31:0]);
            else pass_cnt++;
        end
        total_cnt++; if (done_cnt != 1) $display("FAIL postreset done_count: got %0d exp 1", done_cnt); else pass_cnt++;
    endtask

    task automatic test_ignored_start();
        clear_mon();
        build_expected(300, 32, 32, 5);
        start_tile(300, 64, 64, 0, 0, 1'b0);
        stream_rows(0, 5, 5, "restart");
        @(negedge clk);
        BASE_ADDR_in = AW'(500);
        TILE_START_in = 1'b1;
        stream_rows(5, ROWS, 5, "restart");
        wait_done("restart");
        repeat (5) @(negedge clk);
        total_cnt++;
        if (wr_addr_q.size() != exp_addr_q.size()) $display("FAIL restart write_count: got %0d exp %0d", wr_addr_q.size(), exp_addr_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            total_cnt++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_d_q[i] !== exp_d_q[i])
                $display("FAIL restart write%0d: got addr=%0d d0=%h, exp addr=%0d d0=%h", i,
                         wr_addr_q[i], wr_d_q[i][31:0], exp_addr_q[i], exp_d_q[i][31:0]);
            else pass_cnt++;
        end
        total_cnt++; if (done_cnt != 1) $display("FAIL restart done_count: got %0d exp 1", done_cnt); else pass_cnt++;
        total_cnt++; if (BUSY_out !== 1'b0) $display("FAIL restart busy_after: got %b exp 0", BUSY_out); else pass_cnt++;
    endtask

    task automatic test_no_valid_rows();
        clear_mon();
        build_expected(1010, 0, 32, 6);
        start_tile(1010, 16, 64, 32, 0, 1'b0);
        stream_rows(0, ROWS, 6, "norows");
        wait_done("norows");
        total_cnt++;
        if (wr_addr_q.size() != exp_addr_q.size()) $display("FAIL norows write_count: got %0d exp %0d", wr_addr_q.size(), exp_addr_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            total_cnt++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_d_q[i] !== exp_d_q[i] || wr_be_q[i] !== exp_be_q[i])
                $display("FAIL norows write%0d: got addr=%0d d0=%h, exp addr=%0d d0=%h", i,
                         wr_addr_q[i], wr_d_q[i][31:0], exp_addr_q[i], exp_d_q[i][31:0]);
            else pass_cnt++;
        end
        total_cnt++; if (done_cnt != 1) $display("FAIL norows done_count: got %0d exp 1", done_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_full_tile();
        test_partial_tile();
        test_backpressure();
        test_reset_mid_tile();
        test_ignored_start();
        test_no_valid_rows();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/out_sram_writeback.md
Name: out_sram_writeback

Overview:
- Sits directly downstream of the PE array, between its drain output and the output SRAM.
- Accepts one accumulated output row (PE_ARRAY_NUM_COLS x ACC_BWIDTH) per handshake while the array flushes a tile.
- Buffers rows in a small FIFO, generates output-SRAM addresses, and generates bit-enables for partial tiles (M or N not a multiple of the array size).
- Signals tile completion to the controller.

Parameters:
- ACC_BWIDTH, 32, accumulator lane width
- PE_ARRAY_NUM_ROWS, 32, rows drained per tile
- PE_ARRAY_NUM_ROWS_LOG2, 5, log2 of above
- PE_ARRAY_NUM_COLS, 32, lanes per row
- OUT_SRAM_AWIDTH, 10, output SRAM address width
- OUT_SRAM_BWIDTH, 32*32, output SRAM row width (= PE_ARRAY_NUM_COLS*ACC_BWIDTH)
- MAX_M_SIZE_LOG2, 9, width of M size/row base
- MAX_N_SIZE_LOG2, 9, width of N size/col base
- BUF_DEPTH, 4, row buffer entries (power of 2, >=2)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- STALL  in  1  freezes the SRAM write side
- TILE_START_in  in  1  one-cycle pulse that latches the tile config
- TILE_ROW_BASE_in  in  MAX_M_SIZE_LOG2  first output row of the tile
- TILE_COL_BASE_in  in  MAX_N_SIZE_LOG2  first output col of the tile
- BASE_ADDR_in  in  OUT_SRAM_AWIDTH  SRAM address of the tile's local row 0
- M_SIZE_in  in  MAX_M_SIZE_LOG2  matrix rows
- N_SIZE_in  in  MAX_N_SIZE_LOG2  matrix cols
- ROW_VALID_in  in  1  PE array presents a drained row
- ROW_DATA_in  in  OUT_SRAM_BWIDTH  row data; lane j at bits [(j+1)*ACC_BWIDTH-1 : j*ACC_BWIDTH]
- ROW_READY_out  out  1  row accepted when VALID & READY
- OUT_SRAM_ADDR_out  out  OUT_SRAM_AWIDTH  write address
- OUT_SRAM_WEn_out  out  1  active-low write enable
- OUT_SRAM_BE_out  out  OUT_SRAM_BWIDTH  per-bit write enable
- OUT_SRAM_D_out  out  OUT_SRAM_BWIDTH  write data
- BUSY_out  out  1  tile in progress
- TILE_DONE_out  out  1  one-cycle pulse when the tile is fully written

Behaviour:
- Reset (RST=1 at a clock edge, including mid-tile): outputs take these values.
  - ADDR=0, WEn=1, BE=0, D=0, READY=0, BUSY=0, DONE=0.
  - FIFO is emptied, counters are cleared, FSM goes to IDLE.
  - No SRAM write occurs in the reset cycle.

- FSM states: IDLE, DRAIN, FLUSH, DONE.
  - IDLE: READY=0. On TILE_START_in, latch the config, clear counters, go to DRAIN. BUSY=1 from the next cycle.
  - DRAIN: READY = !fifo_full, registered, independent of STALL. Each handshake pushes {row_data, local_row_idx} and increments accept_cnt. When accept_cnt reaches PE_ARRAY_NUM_ROWS, go to FLUSH with READY=0.
  - FLUSH: wait for the FIFO to empty and the last write to issue, then go to DONE.
  - DONE: TILE_DONE_out=1 for one cycle, BUSY=0, go to IDLE.
  - TILE_START_in is ignored outside IDLE.

- Tile bounds, computed at latch time:
  - valid_rows = (ROW_BASE >= M_SIZE) ? 0 : min(PE_ARRAY_NUM_ROWS, M_SIZE-ROW_BASE)
  - valid_cols = (COL_BASE >= N_SIZE) ? 0 : min(PE_ARRAY_NUM_COLS, N_SIZE-COL_BASE)

- Write side: when not STALL and the FIFO is non-empty, pop one entry per cycle.
  - If local_row_idx < valid_rows: register WEn=0, ADDR=BASE_ADDR+local_row_idx (mod 2^AWIDTH), D=row_data, BE lane j = all ones if j < valid_cols, else zero.
  - Otherwise the row is discarded with WEn=1.
  - When no pop occurs: WEn=1, BE=0; ADDR/D hold their values.

- Latency: a row accepted at edge t appears on the SRAM ports after edge t+1 (no stall, FIFO empty).

- STALL: no pop and WEn=1. Accepts continue until the FIFO is full.

- Simultaneous push and pop on a full FIFO cannot occur, because READY is 0 when full. Push and pop in the same cycle otherwise leave the occupancy unchanged.

- valid_rows=0: all rows are accepted and discarded. DONE still pulses after PE_ARRAY_NUM_ROWS accepts.

Optional Feature:
- OUT_WB_ZERO_PAD_EN
- Defined:
  - Out-of-range rows (local_row_idx >= valid_rows) are written as all-zero rows with full BE.
  - Lanes j >= valid_cols are written as zero with BE all ones.
  - Every tile produces exactly PE_ARRAY_NUM_ROWS writes.
- Undefined: the masking and discard behaviour described above applies.

Test Plan:
- Full tile: M=N=64, ROW_BASE=0, COL_BASE=32, BASE_ADDR=100; 32 back-to-back rows, row r lanes = r -> writes at addrs 100..131, BE all ones, D lanes = r, single DONE pulse 1 cycle after the FLUSH exit.
- Partial tile: M=40, N=37, ROW_BASE=32, COL_BASE=32 -> 8 writes at BASE..BASE+7, BE ones only in lanes 0..4, remaining 24 rows discarded, DONE still pulses.
- Backpressure: STALL held high for 10 cycles during DRAIN -> READY drops after 4 accepts (BUF_DEPTH=4), WEn=1 throughout the stall, no row lost or reordered after release.
- Reset mid-tile: RST asserted after 10 accepts -> next cycle WEn=1, BE=0, BUSY=0, READY=0; a new TILE_START completes a clean 32-row tile.
- Ignored start: TILE_START pulsed during DRAIN with different BASE_ADDR -> addresses unchanged, one DONE only.
- ZERO_PAD (macro defined): M=40, ROW_BASE=32 -> 32 writes, rows 8..31 D=0 with BE all ones.
